// File: rtl/multi_edge_pulse_pkg.sv
// Purpose : shared types for the multi-channel edge/pulse block.
// Contents: per-channel edge-select encoding and a helper that decides
//           whether an accepted level change should raise a pulse.
package multi_edge_pulse_pkg;

    // Two-bit per-channel edge select carried on i_mode.
    typedef enum logic [1:0] {
        EDGE_OFF  = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_e;

    localparam int MODE_W = 2;

    // True when a level change in the given direction is selected by mode.
    function automatic logic edge_match(input logic [MODE_W-1:0] mode,
                                        input logic              rising);
        logic hit;
        if (rising) begin
            hit = (mode == EDGE_RISE) || (mode == EDGE_BOTH);
        end else begin
            hit = (mode == EDGE_FALL) || (mode == EDGE_BOTH);
        end
        return hit;
    endfunction

endpackage

// File: rtl/multi_edge_pulse_if.sv
// Purpose : bundles the per-channel data/mode inputs and level/pulse outputs.
// Ports   : i_data, i_mode driven by the master; o_level, o_pulse, o_any
//           driven by the slave (the multi_edge_pulse block).
interface multi_edge_pulse_if #(
    parameter int CHANNELS = 4
);
    import multi_edge_pulse_pkg::*;

    logic [CHANNELS-1:0]        i_data;
    logic [MODE_W*CHANNELS-1:0] i_mode;
    logic [CHANNELS-1:0]        o_level;
    logic [CHANNELS-1:0]        o_pulse;
    logic                       o_any;

    modport master (
        output i_data,
        output i_mode,
        input  o_level,
        input  o_pulse,
        input  o_any
    );

    modport slave (
        input  i_data,
        input  i_mode,
        output o_level,
        output o_pulse,
        output o_any
    );

endinterface

// File: rtl/multi_edge_pulse_channel.sv
// Purpose : one channel: synchroniser, debounce counter, level and pulse regs.
// Latency : level/pulse update SYNC_STAGES+DEBOUNCE_CYCLES-1 edges after the
//           input is first sampled stable; no backpressure (free-running).
// Ports   : i_clk, i_rst (sync, active-high), i_data (async level),
//           i_mode (edge select), o_level (debounced), o_pulse (1-cycle).
module edge_pulse_channel
    import multi_edge_pulse_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_data,
    input  logic [MODE_W-1:0] i_mode,
    output logic              o_level,
    output logic              o_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   pulse_q, pulse_d;
    logic                   s;

    // Newest sample enters at bit 0; the top bit is the synchronised sample.
    assign sync_d = {sync_q[SYNC_STAGES-2:0], i_data};
    assign s      = sync_q[SYNC_STAGES-1];

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        pulse_d = 1'b0;
        if (s == level_q) begin
            // Any agreeing sample breaks a pending run.
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            // Run long enough: accept, and judge the pulse against the
            // mode presented at this very edge.
            level_d = s;
            cnt_d   = '0;
            pulse_d = edge_match(i_mode, s);
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
        end
    end

    assign o_level = level_q;
    assign o_pulse = pulse_q;

endmodule

// File: rtl/multi_edge_pulse.sv
// Purpose : CHANNELS independent debounced edge detectors plus an any-pulse OR.
// Latency : pulse SYNC_STAGES+DEBOUNCE_CYCLES-1 edges after a stable input;
//           no backpressure (outputs are unconditional one-cycle pulses).
// Ports   : i_clk, i_rst (sync, active-high) and the slave side of
//           multi_edge_pulse_if (i_data, i_mode in; o_level, o_pulse, o_any out).
module multi_edge_pulse
    import multi_edge_pulse_pkg::*;
#(
    parameter int CHANNELS        = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    multi_edge_pulse_if.slave   bus
);

    logic [CHANNELS-1:0] level_w;
    logic [CHANNELS-1:0] pulse_w;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        edge_pulse_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_ch (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_data  (bus.i_data[g]),
            .i_mode  (bus.i_mode[MODE_W*g +: MODE_W]),
            .o_level (level_w[g]),
            .o_pulse (pulse_w[g])
        );
    end

    assign bus.o_level = level_w;
    assign bus.o_pulse = pulse_w;
    // Pulses are already registered, so the OR lands in the same cycle.
    assign bus.o_any   = |pulse_w;

endmodule

// File: tb/tb_multi_edge_pulse.sv
module tb_multi_edge_pulse;
    import multi_edge_pulse_pkg::*;

    localparam int CH   = 4;
    localparam int HMAX = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multi_edge_pulse_if #(.CHANNELS(CH)) bus_a ();
    multi_edge_pulse_if #(.CHANNELS(CH)) bus_b ();

    multi_edge_pulse #(.CHANNELS(CH), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut_a (
        .i_clk(clk), .i_rst(rst), .bus(bus_a));
    multi_edge_pulse #(.CHANNELS(CH), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(1)) dut_b (
        .i_clk(clk), .i_rst(rst), .bus(bus_b));

    int checks   = 0;
    int failures = 0;

    // Reference: raw sample history delayed by SYNC edges gives s; a level is
    // accepted when the last DEBOUNCE values of s all disagree with it.
    logic [CH-1:0] raw_h [2][HMAX];
    logic [CH-1:0] s_h   [2][HMAX];
    logic [CH-1:0] m_level [2];
    logic [CH-1:0] m_pulse [2];
    int sync_n [2] = '{2, 3};
    int deb_n  [2] = '{4, 1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input int d, input logic r,
                              input logic [CH-1:0] data, input logic [2*CH-1:0] mode);
        logic [CH-1:0] s;
        logic all_diff, rising;
        logic [1:0] md;
        if (r) begin
            for (int i = 0; i < HMAX; i++) begin
                raw_h[d][i] = '0;
                s_h[d][i]   = '0;
            end
            m_level[d] = '0;
            m_pulse[d] = '0;
            return;
        end
        s = raw_h[d][sync_n[d]-1];
        for (int i = HMAX-1; i > 0; i--) begin
            raw_h[d][i] = raw_h[d][i-1];
            s_h[d][i]   = s_h[d][i-1];
        end
        raw_h[d][0] = data;
        s_h[d][0]   = s;
        m_pulse[d]  = '0;
        for (int c = 0; c < CH; c++) begin
            all_diff = 1'b1;
            for (int j = 0; j < deb_n[d]; j++)
                if (s_h[d][j][c] == m_level[d][c]) all_diff = 1'b0;
            if (all_diff) begin
                rising = s[c];
                m_level[d][c] = s[c];
                md = mode[2*c +: 2];
                m_pulse[d][c] = rising ? (md == 2'b01 || md == 2'b11)
                                       : (md == 2'b10 || md == 2'b11);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(0, rst, bus_a.i_data, bus_a.i_mode);
        model_edge(1, rst, bus_b.i_data, bus_b.i_mode);
        #1;
        chk("a_level", 32'(bus_a.o_level), 32'(m_level[0]));
        chk("a_pulse", 32'(bus_a.o_pulse), 32'(m_pulse[0]));
        chk("a_any",   32'(bus_a.o_any),   32'(|m_pulse[0]));
        chk("b_level", 32'(bus_b.o_level), 32'(m_level[1]));
        chk("b_pulse", 32'(bus_b.o_pulse), 32'(m_pulse[1]));
        chk("b_any",   32'(bus_b.o_any),   32'(|m_pulse[1]));
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        bus_a.i_data = '0;
        bus_b.i_data = '0;
        repeat (n) step();
        chk("rst_a_level", 32'(bus_a.o_level), 32'd0);
        chk("rst_a_pulse", 32'(bus_a.o_pulse), 32'd0);
        chk("rst_b_any",   32'(bus_b.o_any),   32'd0);
        rst = 1'b0;
    endtask

    initial begin
        logic [CH-1:0] prev_p, flip;
        bus_a.i_data = '0; bus_a.i_mode = '0;
        bus_b.i_data = '0; bus_b.i_mode = '0;

        // Single rising edge, ch0 rise-only: pulse at edge 5 only.
        do_reset(2);
        bus_a.i_mode = 8'b00_00_00_01;
        bus_a.i_data = 4'b0001;
        for (int k = 0; k < 9; k++) begin
            step();
            chk("rise_ch0_pulse", 32'(bus_a.o_pulse), (k == 5) ? 32'h1 : 32'h0);
            chk("rise_ch0_level", 32'(bus_a.o_level[0]), (k >= 5) ? 32'h1 : 32'h0);
        end

        // Short 3-cycle glitch on ch1: nothing.
        do_reset(2);
        bus_a.i_mode = 8'b00_00_11_00;
        bus_a.i_data = 4'b0010;
        for (int k = 0; k < 10; k++) begin
            if (k == 3) bus_a.i_data = '0;
            step();
            chk("glitch_ch1_pulse", 32'(bus_a.o_pulse[1]), 32'h0);
            chk("glitch_ch1_level", 32'(bus_a.o_level[1]), 32'h0);
        end

        // 4-cycle high on ch1, both edges: rise at 5, fall at 9.
        do_reset(2);
        bus_a.i_data = 4'b0010;
        for (int k = 0; k < 12; k++) begin
            if (k == 4) bus_a.i_data = '0;
            step();
            chk("pulse4_ch1", 32'(bus_a.o_pulse[1]), (k == 5 || k == 9) ? 32'h1 : 32'h0);
        end

        // ch2 fall-only, then mode off: level tracks, pulse only on fall.
        for (int pass = 0; pass < 2; pass++) begin
            do_reset(2);
            bus_a.i_mode = (pass == 0) ? 8'b00_10_00_00 : 8'b00_00_00_00;
            bus_a.i_data = 4'b0100;
            for (int k = 0; k < 16; k++) begin
                if (k == 8) bus_a.i_data = '0;
                step();
                chk("ch2_level", 32'(bus_a.o_level[2]), (k >= 5 && k < 13) ? 32'h1 : 32'h0);
                chk("ch2_pulse", 32'(bus_a.o_pulse[2]),
                    (pass == 0 && k == 13) ? 32'h1 : 32'h0);
            end
        end

        // All channels rise together.
        do_reset(2);
        bus_a.i_mode = 8'b01_01_01_01;
        bus_a.i_data = 4'hF;
        for (int k = 0; k < 9; k++) begin
            step();
            chk("all_pulse", 32'(bus_a.o_pulse), (k == 5) ? 32'hF : 32'h0);
            chk("all_any",   32'(bus_a.o_any),   (k == 5) ? 32'h1 : 32'h0);
        end

        // Reset mid-debounce, input held high.
        do_reset(2);
        bus_a.i_mode = 8'b00_00_00_01;
        bus_a.i_data = 4'b0001;
        repeat (4) step();
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            chk("midrst_pulse", 32'(bus_a.o_pulse), 32'h0);
            chk("midrst_level", 32'(bus_a.o_level), 32'h0);
        end
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("postrst_pulse", 32'(bus_a.o_pulse), (k == 5) ? 32'h1 : 32'h0);
        end

        // Fast build: step at edge 0 pulses at edge 3.
        do_reset(2);
        bus_b.i_mode = 8'b00_00_11_01;
        bus_b.i_data = 4'b0001;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("fast_step_pulse", 32'(bus_b.o_pulse[0]), (k == 3) ? 32'h1 : 32'h0);
        end
        // Alternate ch1 every 2 cycles; pulses never back to back.
        prev_p = '0;
        for (int k = 0; k < 24; k++) begin
            if (k % 2 == 0) bus_b.i_data[1] = ~bus_b.i_data[1];
            step();
            chk("fast_noconsec", 32'(prev_p & bus_b.o_pulse), 32'h0);
            chk("fast_alt_pulse", 32'(bus_b.o_pulse[1]),
                (k >= 3 && (k % 2) == 1) ? 32'h1 : 32'h0);
            prev_p = bus_b.o_pulse;
        end

        // Randomised traffic on both builds against the reference.
        do_reset(2);
        for (int k = 0; k < 600; k++) begin
            flip = '0;
            for (int c = 0; c < CH; c++) if ($urandom_range(0, 5) == 0) flip[c] = 1'b1;
            bus_a.i_data ^= flip;
            flip = '0;
            for (int c = 0; c < CH; c++) if ($urandom_range(0, 3) == 0) flip[c] = 1'b1;
            bus_b.i_data ^= flip;
            if ($urandom_range(0, 19) == 0) bus_a.i_mode = 8'($urandom);
            if ($urandom_range(0, 19) == 0) bus_b.i_mode = 8'($urandom);
            rst = ($urandom_range(0, 149) == 0);
            step();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
